// File: rtl/mem_wb_hilo.sv
// MEM/WB pipeline latch with architectural HI/LO pair, WB->EX HI/LO bypass
// and a retired-instruction counter.
module mem_wb_hilo #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             valid,
    input  logic             we,
    input  logic [4:0]       waddr,
    input  logic [31:0]      wdata,
    input  logic             we_hilo,
    input  logic [31:0]      hi,
    input  logic [31:0]      lo,
    output logic             we_o,
    output logic [4:0]       waddr_o,
    output logic [31:0]      wdata_o,
    output logic [31:0]      hi_rd,
    output logic [31:0]      lo_rd,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    logic          valid_q,   valid_d;
    logic          we_q,      we_d;
    logic [AW-1:0] waddr_q,   waddr_d;
    logic [DW-1:0] wdata_q,   wdata_d;
    logic          we_hilo_q, we_hilo_d;
    logic [DW-1:0] hi_q,      hi_d;
    logic [DW-1:0] lo_q,      lo_d;
    logic [DW-1:0] hi_arch_q, hi_arch_d;
    logic [DW-1:0] lo_arch_q, lo_arch_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    // The latch entry leaves WB whenever it is not held; a flush always evicts it.
    logic advance_c;
    assign advance_c = !stall || flush;

    always_comb begin
        valid_d   = valid_q;
        we_d      = we_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        we_hilo_d = we_hilo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        hi_arch_d = hi_arch_q;
        lo_arch_d = lo_arch_q;
        retired_d = retired_q;

        if (flush) begin
            valid_d   = 1'b0;
            we_d      = 1'b0;
            waddr_d   = '0;
            wdata_d   = '0;
            we_hilo_d = 1'b0;
            hi_d      = '0;
            lo_d      = '0;
        end else if (!stall) begin
            valid_d   = valid;
            we_d      = we;
            waddr_d   = waddr;
            wdata_d   = wdata;
            we_hilo_d = we_hilo;
            hi_d      = hi;
            lo_d      = lo;
        end

        // Commit and retirement act on the pre-edge latch contents.
        if (we_hilo_q && advance_c) begin
            hi_arch_d = hi_q;
            lo_arch_d = lo_q;
        end
        if (valid_q && advance_c) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            we_hilo_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            hi_arch_q <= '0;
            lo_arch_q <= '0;
            retired_q <= '0;
        end else begin
            valid_q   <= valid_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            we_hilo_q <= we_hilo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            hi_arch_q <= hi_arch_d;
            lo_arch_q <= lo_arch_d;
            retired_q <= retired_d;
        end
    end

    assign we_o    = we_q;
    assign waddr_o = waddr_q;
    assign wdata_o = wdata_q;
    assign retired = retired_q;

    // EX sees a pending HI/LO write straight from the latch.
    assign hi_rd = we_hilo_q ? hi_q : hi_arch_q;
    assign lo_rd = we_hilo_q ? lo_q : lo_arch_q;

endmodule

// File: tb/tb_mem_wb_hilo.sv
// Directed self-checking bench for mem_wb_hilo: reset, load latency, HI/LO
// bypass and commit, stall, flush, counter wrap and back-to-back HI/LO writes.
module tb_mem_wb_hilo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, valid, we, we_hilo;
    logic [4:0]  waddr;
    logic [31:0] wdata, hi, lo;
    logic        we_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o, hi_rd, lo_rd;
    logic [31:0] retired;

    logic        valid8;
    logic        we_o8;
    logic [4:0]  waddr_o8;
    logic [31:0] wdata_o8, hi_rd8, lo_rd8;
    logic [7:0]  retired8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_wb_hilo #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid(valid),
        .we(we), .waddr(waddr), .wdata(wdata), .we_hilo(we_hilo), .hi(hi), .lo(lo),
        .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
        .hi_rd(hi_rd), .lo_rd(lo_rd), .retired(retired)
    );

    mem_wb_hilo #(.CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .stall(1'b0), .flush(1'b0), .valid(valid8),
        .we(1'b0), .waddr(5'd0), .wdata(32'd0), .we_hilo(1'b0), .hi(32'd0), .lo(32'd0),
        .we_o(we_o8), .waddr_o(waddr_o8), .wdata_o(wdata_o8),
        .hi_rd(hi_rd8), .lo_rd(lo_rd8), .retired(retired8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; valid = 0; we = 0; we_hilo = 0;
        waddr = '0; wdata = '0; hi = '0; lo = '0; valid8 = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        step();
        rst_n = 1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        valid = 1; we = 1; waddr = 5'd12; wdata = 32'h1234_5678;
        we_hilo = 1; hi = 32'h99; lo = 32'h77;
        step();
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (we_o !== 1'b0 || waddr_o !== 5'd0 || wdata_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_gpr: we_o=%0b waddr_o=%0d wdata_o=%h required 0/0/0", we_o, waddr_o, wdata_o);
        end
        checks++;
        if (hi_rd !== 32'd0 || lo_rd !== 32'd0 || retired !== 32'd0) begin
            errors++;
            $display("FAIL reset_hilo_cnt: hi_rd=%h lo_rd=%h retired=%0d required 0/0/0", hi_rd, lo_rd, retired);
        end
        idle_inputs();
        step();
        rst_n = 1;
        #1;
        we = 1; waddr = 5'd5; wdata = 32'hDEAD_BEEF; valid = 1;
        #2;
        checks++;
        if (we_o !== 1'b0 || waddr_o !== 5'd0) begin
            errors++;
            $display("FAIL pre_edge_latency: we_o=%0b waddr_o=%0d required 0/0", we_o, waddr_o);
        end
        step();
        checks++;
        if (we_o !== 1'b1 || waddr_o !== 5'd5 || wdata_o !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL load_after_reset: we_o=%0b waddr_o=%0d wdata_o=%h required 1/5/deadbeef", we_o, waddr_o, wdata_o);
        end
        idle_inputs();
    endtask

    task automatic test_waddr_zero();
        do_reset();
        valid = 1; we = 1; waddr = 5'd0; wdata = 32'hCAFE_0001;
        step();
        checks++;
        if (we_o !== 1'b1 || waddr_o !== 5'd0 || wdata_o !== 32'hCAFE_0001) begin
            errors++;
            $display("FAIL waddr_zero_unmasked: we_o=%0b waddr_o=%0d wdata_o=%h required 1/0/cafe0001", we_o, waddr_o, wdata_o);
        end
        idle_inputs();
    endtask

    task automatic test_hilo_bypass();
        do_reset();
        valid = 1; we_hilo = 1; hi = 32'h11; lo = 32'h22;
        step();
        checks++;
        if (hi_rd !== 32'h11 || lo_rd !== 32'h22) begin
            errors++;
            $display("FAIL hilo_bypass: hi_rd=%h lo_rd=%h required 11/22", hi_rd, lo_rd);
        end
        we_hilo = 0; valid = 0; hi = 32'hFF; lo = 32'hEE;
        step();
        step();
        checks++;
        if (hi_rd !== 32'h11 || lo_rd !== 32'h22) begin
            errors++;
            $display("FAIL hilo_arch_persist: hi_rd=%h lo_rd=%h required 11/22", hi_rd, lo_rd);
        end
        idle_inputs();
    endtask

    task automatic test_stall();
        do_reset();
        valid = 1; we = 1; waddr = 5'd3; wdata = 32'h3333;
        step();
        stall = 1; waddr = 5'd7; wdata = 32'h7777; valid = 1;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (waddr_o !== 5'd3 || wdata_o !== 32'h3333 || we_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold: waddr_o=%0d wdata_o=%h we_o=%0b required 3/3333/1", waddr_o, wdata_o, we_o);
        end
        checks++;
        if (retired !== 32'd0) begin
            errors++;
            $display("FAIL stall_no_retire: retired=%0d required 0", retired);
        end
        stall = 0; valid = 0; we = 0;
        step();
        step();
        checks++;
        if (retired !== 32'd1) begin
            errors++;
            $display("FAIL stall_retire_once: retired=%0d required 1", retired);
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        do_reset();
        we_hilo = 1; hi = 32'hAA; lo = 32'hBB;
        step();
        flush = 1; we_hilo = 0; valid = 1; we = 1; waddr = 5'd9; wdata = 32'h9999;
        hi = 32'h1; lo = 32'h2;
        step();
        checks++;
        if (we_o !== 1'b0 || waddr_o !== 5'd0 || wdata_o !== 32'd0) begin
            errors++;
            $display("FAIL flush_bubble: we_o=%0b waddr_o=%0d wdata_o=%h required 0/0/0", we_o, waddr_o, wdata_o);
        end
        checks++;
        if (hi_rd !== 32'hAA || lo_rd !== 32'hBB) begin
            errors++;
            $display("FAIL flush_commits_hilo: hi_rd=%h lo_rd=%h required aa/bb", hi_rd, lo_rd);
        end
        flush = 0; valid = 0; we = 0;
        step();
        checks++;
        if (retired !== 32'd0) begin
            errors++;
            $display("FAIL flush_no_retire: retired=%0d required 0", retired);
        end
        idle_inputs();
    endtask

    task automatic test_counter_wrap();
        do_reset();
        valid8 = 1;
        for (int i = 0; i < 256; i++) step();
        checks++;
        if (retired8 !== 8'd255) begin
            errors++;
            $display("FAIL wrap_preload: retired=%0d required 255", retired8);
        end
        step();
        checks++;
        if (retired8 !== 8'd0) begin
            errors++;
            $display("FAIL wrap_to_zero: retired=%0d required 0", retired8);
        end
        valid8 = 0;
        step();
        checks++;
        if (retired8 !== 8'd1) begin
            errors++;
            $display("FAIL wrap_continue: retired=%0d required 1", retired8);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_hi [3];
        logic [31:0] exp_lo [3];
        exp_hi = '{32'd1, 32'd2, 32'd3};
        exp_lo = '{32'h10, 32'h20, 32'h30};
        do_reset();
        we_hilo = 1;
        for (int i = 0; i < 3; i++) begin
            hi = exp_hi[i]; lo = exp_lo[i];
            step();
            checks++;
            if (hi_rd !== exp_hi[i] || lo_rd !== exp_lo[i]) begin
                errors++;
                $display("FAIL b2b_write%0d: hi_rd=%h lo_rd=%h required %h/%h", i, hi_rd, lo_rd, exp_hi[i], exp_lo[i]);
            end
        end
        we_hilo = 0; hi = 32'h5555; lo = 32'h6666;
        step();
        step();
        checks++;
        if (hi_rd !== 32'd3 || lo_rd !== 32'h30) begin
            errors++;
            $display("FAIL b2b_arch_final: hi_rd=%h lo_rd=%h required 3/30", hi_rd, lo_rd);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        #1;
        test_reset();
        test_waddr_zero();
        test_hilo_bypass();
        test_stall();
        test_flush();
        test_counter_wrap();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
